// File: rtl/regfile_mp.sv
// Multi-port register file with ALU and load write ports, an optional
// hardwired zero register, optional write-to-read bypass, and a
// per-register pending-load scoreboard feeding a hazard flag.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic                     hazard,
  input  logic                     wa_en,
  input  logic [ADDR_W-1:0]        wa_addr,
  input  logic [DATA_W-1:0]        wa_data,
  input  logic                     wl_en,
  input  logic [ADDR_W-1:0]        wl_addr,
  input  logic [DATA_W-1:0]        wl_data,
  input  logic                     bs_en,
  input  logic [ADDR_W-1:0]        bs_addr
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] regs;
  logic [DEPTH-1:0]             busy;

  // Qualified enables: with a zero register, anything aimed at r0 is dropped
  logic wa_ok, wl_ok, bs_ok;

  // Drop writes and busy sets that target the hardwired zero register
  always_comb begin
    wa_ok = wa_en;
    wl_ok = wl_en;
    bs_ok = bs_en;
    if (ZERO_REG != 0) begin
      if (wa_addr == '0) wa_ok = 1'b0;
      if (wl_addr == '0) wl_ok = 1'b0;
      if (bs_addr == '0) bs_ok = 1'b0;
    end
  end

  // Register storage; ALU write is applied last so it wins an address clash
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      regs <= '0;
    end else begin
      if (wl_ok) regs[wl_addr] <= wl_data;
      if (wa_ok) regs[wa_addr] <= wa_data;
    end
  end

  // Pending-load scoreboard; set is applied last so it wins over load clear
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy <= '0;
    end else begin
      if (wl_ok) busy[wl_addr] <= 1'b0;
      if (bs_ok) busy[bs_addr] <= 1'b1;
    end
  end

  // One independent read lane per port
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    regfile_mp_rdport #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_rd (
      .addr    (rd_addr[i*ADDR_W +: ADDR_W]),
      .regs    (regs),
      .busy    (busy),
      .wa_en   (wa_en),
      .wa_addr (wa_addr),
      .wa_data (wa_data),
      .wl_en   (wl_en),
      .wl_addr (wl_addr),
      .wl_data (wl_data),
      .rdata   (rd_data[i*DATA_W +: DATA_W]),
      .rbusy   (rd_busy[i])
    );
  end

  // Any port touching a pending-load register stalls the pipe
  always_comb begin
    hazard = |rd_busy;
  end

endmodule

// Single combinational read lane: stored value, optional same-cycle
// forwarding from the write ports, and zero-register masking.
module regfile_mp_rdport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic [ADDR_W-1:0]                   addr,
  input  logic [2**ADDR_W-1:0][DATA_W-1:0]    regs,
  input  logic [2**ADDR_W-1:0]                busy,
  input  logic                                wa_en,
  input  logic [ADDR_W-1:0]                   wa_addr,
  input  logic [DATA_W-1:0]                   wa_data,
  input  logic                                wl_en,
  input  logic [ADDR_W-1:0]                   wl_addr,
  input  logic [DATA_W-1:0]                   wl_data,
  output logic [DATA_W-1:0]                   rdata,
  output logic                                rbusy
);

  logic hit_wa, hit_wl;

  // Read mux: ALU result is younger than the load, so it forwards first;
  // an arriving load also hides the busy bit it is about to clear
  always_comb begin
    hit_wa = wa_en && (wa_addr == addr);
    hit_wl = wl_en && (wl_addr == addr);
    rdata  = regs[addr];
    rbusy  = busy[addr];
    if (BYPASS != 0) begin
      if (hit_wa)      rdata = wa_data;
      else if (hit_wl) rdata = wl_data;
      if (hit_wl)      rbusy = 1'b0;
    end
    if ((ZERO_REG != 0) && (addr == '0)) begin
      rdata = '0;
      rbusy = 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: one bypassing and one non-bypassing instance share
// stimulus; expected read results are queued and popped at sample time.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic                clock, reset_n;
  logic [NR*AW-1:0]    rd_addr;
  logic [NR*DW-1:0]    rd_data_b, rd_data_n;
  logic [NR-1:0]       rd_busy_b, rd_busy_n;
  logic                hazard_b, hazard_n;
  logic                wa_en, wl_en, bs_en;
  logic [AW-1:0]       wa_addr, wl_addr, bs_addr;
  logic [DW-1:0]       wa_data, wl_data;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1)) dut_b (
    .clock(clock), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .rd_busy(rd_busy_b), .hazard(hazard_b),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wl_en(wl_en), .wl_addr(wl_addr), .wl_data(wl_data),
    .bs_en(bs_en), .bs_addr(bs_addr));

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(0)) dut_n (
    .clock(clock), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data_n),
    .rd_busy(rd_busy_n), .hazard(hazard_n),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wl_en(wl_en), .wl_addr(wl_addr), .wl_data(wl_data),
    .bs_en(bs_en), .bs_addr(bs_addr));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // kind: 0 = rd_data, 1 = rd_busy, 2 = hazard
  typedef struct {
    string       tag;
    bit          nb;
    int          port;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;

  // reference state, kept in step with every clock edge
  logic [31:0] mregs [32];
  logic        mbusy [32];

  function automatic void mclear();
    for (int i = 0; i < 32; i++) begin
      mregs[i] = '0;
      mbusy[i] = 1'b0;
    end
  endfunction

  function automatic void mcommit();
    if (!reset_n) begin
      mclear();
    end else begin
      if (wl_en && wl_addr != 0) begin mregs[wl_addr] = wl_data; mbusy[wl_addr] = 1'b0; end
      if (wa_en && wa_addr != 0) mregs[wa_addr] = wa_data;
      if (bs_en && bs_addr != 0) mbusy[bs_addr] = 1'b1;
    end
  endfunction

  function automatic void mread(input bit byp, input logic [4:0] a,
                                output logic [31:0] d, output logic b);
    d = mregs[a];
    b = mbusy[a];
    if (byp) begin
      if (wa_en && wa_addr == a)      d = wa_data;
      else if (wl_en && wl_addr == a) d = wl_data;
      if (wl_en && wl_addr == a)      b = 1'b0;
    end
    if (a == 0) begin
      d = '0;
      b = 1'b0;
    end
  endfunction

  task automatic push(input string tag, input bit nb, input int port, input int kind,
                      input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.nb = nb; e.port = port; e.kind = kind; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic exp_rd(input string tag, input bit nb, input int port,
                        input logic [31:0] d, input logic b);
    push(tag, nb, port, 0, d);
    push(tag, nb, port, 1, {31'b0, b});
  endtask

  task automatic exp_hz(input string tag, input bit nb, input logic h);
    push(tag, nb, 0, 2, {31'b0, h});
  endtask

  // expected values for every port of both instances from the model
  task automatic exp_model(input string tag);
    logic [31:0] d;
    logic        b, h;
    for (int n = 0; n < 2; n++) begin
      h = 1'b0;
      for (int p = 0; p < NR; p++) begin
        mread(n == 0, rd_addr[p*AW +: AW], d, b);
        exp_rd(tag, n != 0, p, d, b);
        h = h | b;
      end
      exp_hz(tag, n != 0, h);
    end
  endtask

  // let combinational outputs settle, then drain the scoreboard
  task automatic check();
    exp_t        e;
    logic [31:0] act;
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        0:       act = e.nb ? rd_data_n[e.port*DW +: DW] : rd_data_b[e.port*DW +: DW];
        1:       act = {31'b0, (e.nb ? rd_busy_n[e.port] : rd_busy_b[e.port])};
        default: act = {31'b0, (e.nb ? hazard_n : hazard_b)};
      endcase
      checks++;
      assert (act === e.exp) else begin
        failures++;
        $error("FAIL %s nb=%0d port=%0d kind=%0d observed=%h expected=%h",
               e.tag, e.nb, e.port, e.kind, act, e.exp);
      end
    end
  endtask

  task automatic tick();
    mcommit();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    wa_en = 1'b0; wl_en = 1'b0; bs_en = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    wa_addr = '0; wl_addr = '0; bs_addr = '0;
    wa_data = '0; wl_data = '0;
    rd(5'd5, 5'd7);
    mclear();

    // reset state
    #3;
    exp_rd("rst0", 0, 0, 32'h0, 1'b0); exp_rd("rst0", 1, 1, 32'h0, 1'b0);
    exp_hz("rst0", 0, 1'b0);           exp_hz("rst0", 1, 1'b0);
    check();
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // basic ALU write of r5: old value visible only without bypass
    rd(5'd5, 5'd5);
    wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'hDEADBEEF;
    exp_rd("wr_same", 0, 0, 32'hDEADBEEF, 1'b0); exp_rd("wr_same", 0, 1, 32'hDEADBEEF, 1'b0);
    exp_rd("wr_same", 1, 0, 32'h0, 1'b0);        exp_rd("wr_same", 1, 1, 32'h0, 1'b0);
    check();
    tick(); idle();
    exp_rd("wr_after", 0, 0, 32'hDEADBEEF, 1'b0); exp_rd("wr_after", 1, 0, 32'hDEADBEEF, 1'b0);
    exp_rd("wr_after", 1, 1, 32'hDEADBEEF, 1'b0);
    check();

    // ALU and load to the same register: ALU wins both forward and store
    rd(5'd7, 5'd5);
    wa_en = 1'b1; wa_addr = 5'd7; wa_data = 32'h11111111;
    wl_en = 1'b1; wl_addr = 5'd7; wl_data = 32'h22222222;
    exp_rd("prio_same", 0, 0, 32'h11111111, 1'b0); exp_rd("prio_same", 1, 0, 32'h0, 1'b0);
    check();
    tick(); idle();
    exp_rd("prio_after", 0, 0, 32'h11111111, 1'b0); exp_rd("prio_after", 1, 0, 32'h11111111, 1'b0);
    check();

    // zero register ignores writes and busy sets
    rd(5'd0, 5'd0);
    wa_en = 1'b1; wa_addr = 5'd0; wa_data = 32'hFFFFFFFF;
    bs_en = 1'b1; bs_addr = 5'd0;
    exp_rd("zero_same", 0, 0, 32'h0, 1'b0); exp_rd("zero_same", 1, 1, 32'h0, 1'b0);
    check();
    tick(); idle();
    exp_rd("zero_after", 0, 0, 32'h0, 1'b0); exp_rd("zero_after", 1, 0, 32'h0, 1'b0);
    exp_hz("zero_after", 0, 1'b0);           exp_hz("zero_after", 1, 1'b0);
    check();

    // scoreboard set on r3: visible from the next cycle only
    rd(5'd3, 5'd5);
    bs_en = 1'b1; bs_addr = 5'd3;
    exp_rd("bs_same", 0, 0, 32'h0, 1'b0); exp_hz("bs_same", 0, 1'b0);
    check();
    tick(); idle();
    exp_rd("bs_after", 0, 0, 32'h0, 1'b1); exp_rd("bs_after", 1, 0, 32'h0, 1'b1);
    exp_hz("bs_after", 0, 1'b1);           exp_hz("bs_after", 1, 1'b1);
    check();

    // load returns on r3: bypass hides busy and forwards the data
    wl_en = 1'b1; wl_addr = 5'd3; wl_data = 32'h12345678;
    exp_rd("wl_same", 0, 0, 32'h12345678, 1'b0); exp_hz("wl_same", 0, 1'b0);
    exp_rd("wl_same", 1, 0, 32'h0, 1'b1);        exp_hz("wl_same", 1, 1'b1);
    check();
    tick(); idle();
    exp_rd("wl_after", 0, 0, 32'h12345678, 1'b0); exp_rd("wl_after", 1, 0, 32'h12345678, 1'b0);
    exp_hz("wl_after", 0, 1'b0);                  exp_hz("wl_after", 1, 1'b0);
    check();

    // set and clear on r9 together: set wins, data still stored
    rd(5'd9, 5'd9);
    bs_en = 1'b1; bs_addr = 5'd9;
    wl_en = 1'b1; wl_addr = 5'd9; wl_data = 32'hCAFEF00D;
    exp_rd("coll_same", 0, 0, 32'hCAFEF00D, 1'b0); exp_rd("coll_same", 1, 0, 32'h0, 1'b0);
    check();
    tick(); idle();
    exp_rd("coll_after", 0, 1, 32'hCAFEF00D, 1'b1); exp_rd("coll_after", 1, 0, 32'hCAFEF00D, 1'b1);
    exp_hz("coll_after", 0, 1'b1);                  exp_hz("coll_after", 1, 1'b1);
    check();

    // both write ports to different registers commit together
    rd(5'd10, 5'd11);
    wa_en = 1'b1; wa_addr = 5'd10; wa_data = 32'h0000000A;
    wl_en = 1'b1; wl_addr = 5'd11; wl_data = 32'h0000000B;
    tick(); idle();
    exp_rd("dual", 1, 0, 32'h0000000A, 1'b0); exp_rd("dual", 1, 1, 32'h0000000B, 1'b0);
    exp_rd("dual", 0, 0, 32'h0000000A, 1'b0); exp_hz("dual", 0, 1'b0);
    check();

    // asynchronous reset mid-cycle clears data and pending loads at once
    rd(5'd9, 5'd5);
    exp_hz("pre_rst", 0, 1'b1);
    check();
    reset_n = 1'b0;
    mclear();
    #1;
    exp_rd("arst", 0, 0, 32'h0, 1'b0); exp_rd("arst", 0, 1, 32'h0, 1'b0);
    exp_rd("arst", 1, 0, 32'h0, 1'b0); exp_rd("arst", 1, 1, 32'h0, 1'b0);
    exp_hz("arst", 0, 1'b0);           exp_hz("arst", 1, 1'b0);
    check();
    // writes and busy sets during reset are ignored
    wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'h55555555;
    bs_en = 1'b1; bs_addr = 5'd5;
    tick(); idle();
    reset_n = 1'b1;
    exp_rd("rst_wr", 0, 1, 32'h0, 1'b0); exp_rd("rst_wr", 1, 1, 32'h0, 1'b0);
    check();

    // random traffic over a small address window to provoke collisions
    for (int c = 0; c < 300; c++) begin
      wa_en   = ($urandom_range(0, 2) == 0);
      wl_en   = ($urandom_range(0, 2) == 0);
      bs_en   = ($urandom_range(0, 3) == 0);
      wa_addr = 5'($urandom_range(0, 7));
      wl_addr = 5'($urandom_range(0, 7));
      bs_addr = 5'($urandom_range(0, 7));
      wa_data = $urandom;
      wl_data = $urandom;
      rd(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      exp_model("rand");
      check();
      tick();
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
